// File: rtl/shift_multiplier_if.sv
// Operand/result bundle for the shift-and-add multiplier.
// The master side supplies operands and the start request; the slave side
// (the multiplier itself) returns the product together with busy/done status.
interface shift_multiplier_if #(
    parameter int size = 6
);
    logic [size-1:0]   multiplier;
    logic [size-1:0]   multiplicand;
    logic              start;
    logic [2*size-1:0] product;
    logic              busy;
    logic              done;

    modport master (
        output multiplier,
        output multiplicand,
        output start,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  multiplier,
        input  multiplicand,
        input  start,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// One multiplier bit is resolved per clock, LSB first. An operation takes
// `size` cycles in BUSY plus one cycle in DONE, after which the product
// register is loaded and a one-cycle done pulse is raised. Operands are
// captured on the start edge, so later changes on the bus have no effect.
module shift_multiplier #(
    parameter int size = 6
) (
    input  logic              clk,
    input  logic              rst,
    shift_multiplier_if.slave bus
);

    localparam int cnt_w = $clog2(size + 1);
    localparam logic [cnt_w-1:0] last_count = cnt_w'(size - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [2*size-1:0] a;
    logic [size-1:0]   b;
    logic [2*size-1:0] acc;
    logic [cnt_w-1:0]  count;
    logic [2*size-1:0] result;
    logic              busy_flag;
    logic              done_flag;

    // Next-state selection: start is only honoured in IDLE, BUSY ends after the last bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == last_count) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; an asynchronous reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: capture operands on start, then add-and-shift once per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a     <= {{size{1'b0}}, bus.multiplicand};
                        b     <= bus.multiplier;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    if (b[0]) begin
                        acc <= acc + a;
                    end
                    a     <= a << 1;
                    b     <= b >> 1;
                    count <= count + 1'b1;
                end
                default: begin
                    a     <= a;
                    b     <= b;
                    acc   <= acc;
                    count <= count;
                end
            endcase
        end
    end

    // Registered status and result: busy covers BUSY and DONE, done pulses as the product loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_flag <= 1'b1;
                    end
                end
                DONE: begin
                    result    <= acc;
                    done_flag <= 1'b1;
                    busy_flag <= 1'b0;
                end
                default: begin
                    busy_flag <= busy_flag;
                end
            endcase
        end
    end

    assign bus.product = result;
    assign bus.busy    = busy_flag;
    assign bus.done    = done_flag;

endmodule

// File: tb/tb_shift_multiplier.sv
// Directed self-checking bench for shift_multiplier (size = 6).
// Expected products are hand-computed constants; timing expectations follow
// the start-at-edge-N / done-at-edge-N+7 schedule of the multiplier.
module tb_shift_multiplier;

    localparam int size = 6;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    shift_multiplier_if #(.size(size)) bus ();

    shift_multiplier #(.size(size)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int mult, input int mcand, input logic go);
        bus.multiplier   = mult[size-1:0];
        bus.multiplicand = mcand[size-1:0];
        bus.start        = go;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // perturb: 0 = none, 1 = change operands to 5 after edge N+2,
    //          2 = pulse start during BUSY (edge N+4 samples it high)
    task automatic runOp(input string tag, input int mult, input int mcand,
                         input int expected, input int perturb);
        applyStimulus(mult, mcand, 1'b1);
        tick();
        bus.start = 1'b0;
        checkOutput({tag, "_busy_n0"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_done_n0"}, 32'(bus.done), 32'd0);
        for (int i = 1; i <= size; i++) begin
            tick();
            checkOutput({tag, "_busy_mid"}, 32'(bus.busy), 32'd1);
            checkOutput({tag, "_done_mid"}, 32'(bus.done), 32'd0);
            if (perturb == 1 && i == 2) begin
                applyStimulus(5, 5, 1'b0);
            end
            if (perturb == 2 && i == 3) begin
                bus.start = 1'b1;
            end
            if (perturb == 2 && i == 4) begin
                bus.start = 1'b0;
            end
        end
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
        checkOutput({tag, "_product"}, 32'(bus.product), 32'(expected));
        checkOutput({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        tick();
        checkOutput({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_product_hold"}, 32'(bus.product), 32'(expected));
        checkOutput({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    // Directed sequence
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(0, 0, 1'b0);

        tick();
        checkOutput("reset_product", 32'(bus.product), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        runOp("mul_8x24", 8, 24, 192, 0);
        runOp("mul_0x7", 0, 7, 0, 2);
        runOp("mul_63x63", 63, 63, 3969, 0);
        runOp("mul_20x20_change", 20, 20, 400, 1);

        // Held start: done every 8 cycles, product 15 each time
        applyStimulus(3, 5, 1'b1);
        tick();
        for (int k = 1; k < 30; k++) begin
            tick();
            checkOutput("held_done", 32'(bus.done), (k % 8 == 7) ? 32'd1 : 32'd0);
            if (k % 8 == 7) begin
                checkOutput("held_product", 32'(bus.product), 32'd15);
            end
        end
        bus.start = 1'b0;
        tick();
        checkOutput("held_tail_done30", 32'(bus.done), 32'd0);
        tick();
        checkOutput("held_tail_done31", 32'(bus.done), 32'd1);
        checkOutput("held_tail_product", 32'(bus.product), 32'd15);
        tick();
        checkOutput("held_tail_done32", 32'(bus.done), 32'd0);
        checkOutput("held_tail_busy32", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a BUSY phase
        applyStimulus(9, 9, 1'b1);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_product", 32'(bus.product), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("abort_no_done", 32'(bus.done), 32'd0);
            checkOutput("abort_no_busy", 32'(bus.busy), 32'd0);
        end

        runOp("mul_12x11", 12, 11, 132, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
